// File: rtl/line_buffer_ctrl.sv
// Frame sequencer for a binary KxK line-buffer chain.
// Ports: start/pix_* in; lb_* chain drive; win_* window report; busy/frame_done status.
module line_buffer_ctrl #(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int K     = 3,
  localparam int RW = $clog2(IMG_H),
  localparam int CW = $clog2(IMG_W),
  localparam int NW = $clog2((IMG_W-K+1)*(IMG_H-K+1)+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          pix_valid,
  input  logic          pix_in,
  output logic          pix_ready,
  output logic          lb_shift_en,
  output logic          lb_din,
  output logic          win_valid,
  output logic [RW-1:0] win_row,
  output logic [CW-1:0] win_col,
  output logic [NW-1:0] win_cnt,
  output logic          busy,
  output logic          frame_done
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STREAM,
    DONE
  } state_t;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W-1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H-1);
  localparam logic [RW-1:0] ROW_FILL = RW'(K-2);
  localparam logic [RW-1:0] ROW_K1   = RW'(K-1);
  localparam logic [CW-1:0] COL_K1   = CW'(K-1);

  state_t        state;
  state_t        state_nx;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          acc;
  logic          col_end;
  logic          row_end;
  logic          win_hit;

  assign acc     = pix_valid & pix_ready;
  assign col_end = (col == COL_LAST);
  assign row_end = (row == ROW_LAST);
  // STREAM already implies row >= K-1
  assign win_hit = (state == STREAM) & (col >= COL_K1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    pix_ready  = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = FILL;
      end
      FILL: begin
        pix_ready = 1'b1;
        busy      = 1'b1;
        if (pix_valid && col_end && row == ROW_FILL)
          state_nx = STREAM;
      end
      STREAM: begin
        pix_ready = 1'b1;
        busy      = 1'b1;
        if (pix_valid && col_end && row_end)
          state_nx = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        frame_done = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row         <= '0;
      col         <= '0;
      lb_shift_en <= 1'b0;
      lb_din      <= 1'b0;
      win_valid   <= 1'b0;
      win_row     <= '0;
      win_col     <= '0;
      win_cnt     <= '0;
    end else begin
      lb_shift_en <= acc;
      win_valid   <= acc & win_hit;
      if (acc) lb_din <= pix_in;
      if (state == IDLE && start) begin
        row     <= '0;
        col     <= '0;
        win_cnt <= '0;
      end else if (state == DONE) begin
        row <= '0;
        col <= '0;
      end else if (acc) begin
        // last pixel leaves row parked; DONE clears it
        if (col_end) begin
          col <= '0;
          if (!row_end) row <= row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
        if (win_hit) begin
          win_row <= row - ROW_K1;
          win_col <= col - COL_K1;
          win_cnt <= win_cnt + NW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Self-checking bench for line_buffer_ctrl.
// Scoreboard of accepted pixels vs. chain drive and window reports.
module tb_line_buffer_ctrl;
  localparam int W    = 8;
  localparam int H    = 6;
  localparam int K    = 3;
  localparam int NWIN = (W-K+1)*(H-K+1);

  logic       clk = 0;
  logic       rst = 0;
  logic       start = 0;
  logic       pix_valid = 0;
  logic       pix_in = 0;
  logic       pix_ready;
  logic       lb_shift_en;
  logic       lb_din;
  logic       win_valid;
  logic [2:0] win_row;
  logic [2:0] win_col;
  logic [4:0] win_cnt;
  logic       busy;
  logic       frame_done;

  typedef struct {
    logic       din;
    logic       win;
    logic [2:0] r;
    logic [2:0] c;
    logic [4:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_shift, n_win, first_acc, lr, lc;
  int   row_wins[H];
  logic hold_din = 0;
  logic [2:0] hold_r = 0;
  logic [2:0] hold_c = 0;

  always #5 clk = ~clk;

  line_buffer_ctrl #(.IMG_W(W), .IMG_H(H), .K(K)) dut (
    .clk(clk), .rst(rst), .start(start),
    .pix_valid(pix_valid), .pix_in(pix_in),
    .pix_ready(pix_ready), .lb_shift_en(lb_shift_en),
    .lb_din(lb_din), .win_valid(win_valid),
    .win_row(win_row), .win_col(win_col),
    .win_cnt(win_cnt), .busy(busy),
    .frame_done(frame_done)
  );

  task automatic drive_frame(input bit stall, input int abort_at,
                             input bit poke);
    int   acc = 0;
    int   cyc = 0;
    int   mr = 0;
    int   mc = 0;
    int   mcnt = 0;
    bit   last = 0;
    logic v;
    exp_t e;
    exp_t o;
    n_shift = 0; n_win = 0; first_acc = 0; lr = -1; lc = -1;
    foreach (row_wins[i]) row_wins[i] = 0;
    q.delete();
    @(negedge clk); start = 1; pix_valid = 0;
    @(negedge clk); start = 0;
    while (!last && cyc < 1000) begin
      cyc++;
      checks++;
      if (pix_ready !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL in_frame: ready=%b busy=%b want 1 1 acc=%0d",
                 pix_ready, busy, acc);
      end
      v = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      pix_valid = v;
      pix_in = 1'($urandom);
      start = (poke && acc == 25);
      if (v) begin
        e.din = pix_in;
        e.win = (mr >= K-1 && mc >= K-1);
        e.r = 3'(mr - (K-1));
        e.c = 3'(mc - (K-1));
        if (e.win) mcnt++;
        e.cnt = 5'(mcnt);
        q.push_back(e);
        acc++;
        if (mr == H-1 && mc == W-1) last = 1;
        if (mc == W-1) begin mc = 0; mr++; end
        else mc++;
      end
      @(posedge clk); #1;
      start = 0;
      checks++;
      if (lb_shift_en !== v) begin
        errors++;
        $display("FAIL shift_en: got %b want %b acc=%0d",
                 lb_shift_en, v, acc);
      end
      if (v && q.size() > 0) begin
        o = q.pop_front();
        n_shift++;
        hold_din = o.din;
        checks++;
        if (lb_din !== o.din) begin
          errors++;
          $display("FAIL lb_din: got %b want %b acc=%0d",
                   lb_din, o.din, acc);
        end
        checks++;
        if (win_valid !== o.win) begin
          errors++;
          $display("FAIL win_valid: got %b want %b acc=%0d",
                   win_valid, o.win, acc);
        end
        if (o.win) begin
          hold_r = o.r;
          hold_c = o.c;
          checks++;
          if (win_row !== o.r || win_col !== o.c || win_cnt !== o.cnt) begin
            errors++;
            $display("FAIL win_pos: got r%0d c%0d n%0d want r%0d c%0d n%0d",
                     win_row, win_col, win_cnt, o.r, o.c, o.cnt);
          end
        end
      end else begin
        checks++;
        if (lb_din !== hold_din) begin
          errors++;
          $display("FAIL din_hold: got %b want %b", lb_din, hold_din);
        end
      end
      if (win_valid === 1'b1) begin
        n_win++;
        if (n_win == 1) first_acc = acc;
        lr = int'(win_row);
        lc = int'(win_col);
        if (win_row < 3'(H)) row_wins[win_row]++;
      end else begin
        checks++;
        if (win_row !== hold_r || win_col !== hold_c) begin
          errors++;
          $display("FAIL win_hold: got r%0d c%0d want r%0d c%0d",
                   win_row, win_col, hold_r, hold_c);
        end
      end
      checks++;
      if (frame_done !== last) begin
        errors++;
        $display("FAIL frame_done: got %b want %b acc=%0d",
                 frame_done, last, acc);
      end
      if (abort_at > 0 && acc == abort_at) begin
        #2 rst = 0;
        #1;
        checks++;
        if ({pix_ready, lb_shift_en, lb_din, win_valid, busy, frame_done,
             win_row, win_col, win_cnt} !== '0) begin
          errors++;
          $display("FAIL abort_reset: rdy%b sh%b din%b wv%b bz%b fd%b cnt%0d",
                   pix_ready, lb_shift_en, lb_din, win_valid, busy,
                   frame_done, win_cnt);
        end
        hold_din = 0; hold_r = 0; hold_c = 0;
        q.delete();
        @(negedge clk); rst = 1; pix_valid = 0;
        repeat (3) begin
          @(posedge clk); #1;
          checks++;
          if (frame_done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: fd=%b busy=%b want 0 0",
                     frame_done, busy);
          end
        end
        return;
      end
      if (!last) @(negedge clk);
    end
    if (!last) begin
      errors++;
      $display("FAIL frame_timeout: acc=%0d want %0d", acc, W*H);
    end
    @(negedge clk); pix_valid = 0;
    checks++;
    if (pix_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL done_state: ready=%b busy=%b want 0 1", pix_ready, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || frame_done !== 1'b0 || lb_shift_en !== 1'b0) begin
      errors++;
      $display("FAIL post_frame: busy=%b fd=%b sh=%b want 0 0 0",
               busy, frame_done, lb_shift_en);
    end
    checks++;
    if (win_cnt !== 5'(NWIN)) begin
      errors++;
      $display("FAIL win_cnt_final: got %0d want %0d", win_cnt, NWIN);
    end
  endtask

  task automatic test_reset();
    rst = 0; pix_valid = 1; start = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({pix_ready, lb_shift_en, win_valid, busy, frame_done, win_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_out: rdy%b sh%b wv%b bz%b fd%b cnt%0d want all 0",
               pix_ready, lb_shift_en, win_valid, busy, frame_done, win_cnt);
    end
    @(negedge clk); start = 0; rst = 1;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || pix_ready !== 1'b0 || lb_shift_en !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle: busy=%b ready=%b sh=%b want 0 0 0",
                 busy, pix_ready, lb_shift_en);
      end
    end
    pix_valid = 0;
  endtask

  task automatic test_full_frame();
    drive_frame(0, 0, 0);
    checks++;
    if (n_shift != W*H || n_win != NWIN) begin
      errors++;
      $display("FAIL full_totals: shifts %0d wins %0d want %0d %0d",
               n_shift, n_win, W*H, NWIN);
    end
    checks++;
    if (first_acc != 19) begin
      errors++;
      $display("FAIL first_window: at accept %0d want 19", first_acc);
    end
    checks++;
    if (lr != 3 || lc != 5) begin
      errors++;
      $display("FAIL last_window: r%0d c%0d want r3 c5", lr, lc);
    end
  endtask

  task automatic test_stalls();
    drive_frame(1, 0, 0);
    checks++;
    if (n_shift != W*H || n_win != NWIN || lr != 3 || lc != 5) begin
      errors++;
      $display("FAIL stall_totals: sh%0d win%0d last r%0d c%0d",
               n_shift, n_win, lr, lc);
    end
  endtask

  task automatic test_row_wrap();
    drive_frame(0, 0, 0);
    for (int r = 0; r < H; r++) begin
      checks++;
      if (row_wins[r] != ((r <= H-K) ? W-K+1 : 0)) begin
        errors++;
        $display("FAIL row_wins: row %0d got %0d want %0d", r,
                 row_wins[r], (r <= H-K) ? W-K+1 : 0);
      end
    end
  endtask

  task automatic test_mid_reset();
    drive_frame(0, 30, 0);
    drive_frame(0, 0, 0);
    checks++;
    if (n_win != NWIN || n_shift != W*H) begin
      errors++;
      $display("FAIL reset_refill: wins %0d shifts %0d want %0d %0d",
               n_win, n_shift, NWIN, W*H);
    end
  endtask

  task automatic test_start_in_stream();
    drive_frame(0, 0, 1);
    checks++;
    if (n_win != NWIN) begin
      errors++;
      $display("FAIL start_ignored: wins %0d want %0d", n_win, NWIN);
    end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 2; f++) begin
      drive_frame(f == 1, 0, 0);
      checks++;
      if (n_win != NWIN) begin
        errors++;
        $display("FAIL b2b_frame: frame %0d wins %0d want %0d",
                 f, n_win, NWIN);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_stalls();
    test_row_wrap();
    test_mid_reset();
    test_start_in_stream();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_buffer_ctrl.md
Name: line_buffer_ctrl

Overview:
Frame sequencer for the binary line-buffer chain that forms a KxK sliding window over a single-bit pixel stream.
- Accepts raster-order pixels over a valid/ready handshake.
- Tracks the row and column position of each pixel.
- Drives the shift enable and data input of the line-buffer chain.
- Flags the cycles in which the chain holds a complete KxK window, and reports the window position to the downstream binary convolution stage.

Parameters:
IMG_W, 32, pixels per row; also the depth of each line buffer in the chain; must be >= K.
IMG_H, 32, rows per frame; must be >= K.
K, 3, window edge length; must be >= 2.

Ports:
clk  input  1  clock; all logic on the rising edge.
rst  input  1  asynchronous, active-low reset.
start  input  1  one-cycle pulse that begins a frame; sampled only in IDLE.
pix_valid  input  1  upstream pixel valid.
pix_in  input  1  binary pixel.
pix_ready  output  1  controller can accept a pixel this cycle.
lb_shift_en  output  1  shift enable to the line-buffer chain; the chain holds its contents when low.
lb_din  output  1  pixel written into the head of the chain.
win_valid  output  1  chain holds a full KxK window this cycle.
win_row  output  $clog2(IMG_H)  window top-left row.
win_col  output  $clog2(IMG_W)  window top-left column.
win_cnt  output  $clog2((IMG_W-K+1)*(IMG_H-K+1)+1)  number of windows emitted in the current frame.
busy  output  1  frame in progress.
frame_done  output  1  one-cycle pulse after the last pixel of a frame.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; row=col=0; all outputs 0, including win_cnt. Reset mid-frame aborts the frame immediately, with no frame_done.
- States: IDLE, FILL, STREAM, DONE.
  - IDLE: pix_ready=0, busy=0. start=1 -> FILL; row=col=0; win_cnt=0.
  - FILL: row < K-1. pix_ready=1, busy=1.
  - STREAM: row >= K-1. pix_ready=1, busy=1.
  - DONE: lasts one cycle. pix_ready=0, frame_done=1, busy=1. Unconditionally -> IDLE.
- start is ignored outside IDLE.
- Accept condition: pix_valid & pix_ready.
  - On accept: col increments.
  - At col=IMG_W-1: col wraps to 0 and row increments.
  - When row reaches K-1 on the wrap: FILL -> STREAM.
  - Accept with row=IMG_H-1 and col=IMG_W-1: -> DONE. Counters clear on DONE exit.
- Output latency is one cycle, all registered.
  - The cycle after an accept: lb_shift_en=1 and lb_din=accepted pixel.
  - Otherwise lb_shift_en=0. lb_din holds its last value.
  - pix_valid low in FILL/STREAM is a stall: no shift, counters hold, no window.
- Window rule, using row/col of the accepted pixel (pre-increment):
  - If row >= K-1 and col >= K-1, then in the same cycle as its lb_shift_en: win_valid=1, win_row=row-(K-1), win_col=col-(K-1), win_cnt incremented.
  - Columns 0..K-2 of each row never produce a window; there is no padding.
  - win_row/win_col hold their values when win_valid=0.
- Frame totals:
  - Exactly IMG_W*IMG_H shift pulses and (IMG_W-K+1)*(IMG_H-K+1) windows per frame.
  - win_cnt holds its final value until the next start.
- Timing at the end of a frame: the last window's win_valid coincides with frame_done, both one cycle after the last accept.
- Back-to-back frames: start is accepted in IDLE, which is at least 1 cycle after DONE. Line-buffer contents are not cleared between frames; stale contents are harmless because windows are withheld during FILL.
- Counters are unsigned. No arithmetic overflows at maximum IMG_W/IMG_H per the widths above.

Test Plan:
- Reset: hold rst=0 with pix_valid=1 and start=1 -> pix_ready, lb_shift_en, win_valid, busy, frame_done all 0; win_cnt=0; state stays IDLE for 3 cycles after release without start.
- Full frame (IMG_W=8, IMG_H=6, K=3), continuous pix_valid=1 after start:
  - 48 lb_shift_en pulses; lb_din equals the input sequence delayed by 1 cycle.
  - First win_valid one cycle after the 19th accept (row 2, col 2), with win_row=0, win_col=0.
  - Last window win_row=3, win_col=5.
  - win_cnt=24; frame_done coincides with the 24th window; busy drops the next cycle.
- Stalls: same frame with pix_valid toggled on a random 50% pattern -> identical window sequence and pixel order; no lb_shift_en in any cycle following pix_valid=0.
- Row wrap: at each col=7 accept, the next accept is col=0 of the next row; no win_valid for columns 0-1 of any row; windows per row = 6.
- Mid-frame reset: assert rst=0 after 30 accepts -> all outputs 0 asynchronously, no frame_done; a new start then yields a full, correct 24-window frame.
- Control corner cases:
  - start pulsed during STREAM -> ignored; the frame completes normally.
  - Two frames back-to-back (start the cycle after frame_done ends) -> each frame reports win_cnt=24.
